// File: rtl/symm_iter_ctrl_pkg.sv
// Shared definitions for the FastICA symmetric-decorrelation iteration controller.
package symm_iter_ctrl_pkg;

   localparam int unsigned       SYM_DW  = 26;
   localparam logic [SYM_DW-1:0] SYM_TOL = 26'd64;

   typedef enum logic [2:0] {
      SYM_IDLE   = 3'd0,
      SYM_LOAD   = 3'd1,
      SYM_RUN    = 3'd2,
      SYM_WAIT   = 3'd3,
      SYM_CHECK  = 3'd4,
      SYM_UPDATE = 3'd5,
      SYM_DONE   = 3'd6
   } sym_state_e;

endpackage

// File: rtl/symm_iter_ctrl.sv
// Sequences the symmetric-decorrelation loop: loads W, launches passes, checks
// convergence against TOL and bounds the number of update passes.
module symm_iter_ctrl
   import symm_iter_ctrl_pkg::*;
#(
   parameter int unsigned MAX_ITER = 16,
   parameter int unsigned ITER_W   = 5,
   parameter int unsigned DW       = SYM_DW,
   parameter logic [DW-1:0] TOL    = DW'(SYM_TOL)
) (
   input  logic              clk_sym,
   input  logic              rst_sym,
   input  logic              start,
   input  logic              abort,
   input  logic              dec_done,
   input  logic [DW-1:0]     delta_abs,
   output logic              sel_en,
   output logic              sel_select,
   output logic              dec_start,
   output logic [ITER_W-1:0] iter_cnt,
   output logic              busy,
   output logic              done,
   output logic              converged,
   output logic              timeout
);

   localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(MAX_ITER - 1);

   sym_state_e        state_q, state_d;
   logic [DW-1:0]     delta_q, delta_d;
   logic [ITER_W-1:0] iter_q, iter_d;
   logic              conv_q, conv_d;
   logic              tout_q, tout_d;
   logic              selsel_q, selsel_d;
   logic              selen_q, decst_q, busy_q, done_q;

   always_comb begin
      state_d  = state_q;
      delta_d  = delta_q;
      iter_d   = iter_q;
      conv_d   = conv_q;
      tout_d   = tout_q;
      selsel_d = selsel_q;
      if (abort) begin
         state_d = SYM_IDLE;
      end else begin
         case (state_q)
            SYM_IDLE: begin
               if (start) begin
                  state_d  = SYM_LOAD;
                  iter_d   = '0;
                  conv_d   = 1'b0;
                  tout_d   = 1'b0;
                  selsel_d = 1'b0;
               end
            end
            SYM_LOAD: state_d = SYM_RUN;
            SYM_RUN:  state_d = SYM_WAIT;
            SYM_WAIT: begin
               if (dec_done) begin
                  delta_d = delta_abs;
                  state_d = SYM_CHECK;
               end
            end
            SYM_CHECK: begin
               if (delta_q <= TOL) begin
                  conv_d  = 1'b1;
                  state_d = SYM_DONE;
               end else if (iter_q == LAST_ITER) begin
                  tout_d  = 1'b1;
                  state_d = SYM_DONE;
               end else begin
                  // count is bumped on UPDATE entry so it reads correctly during UPDATE
                  iter_d   = iter_q + 1'b1;
                  selsel_d = 1'b1;
                  state_d  = SYM_UPDATE;
               end
            end
            SYM_UPDATE: state_d = SYM_RUN;
            SYM_DONE:   state_d = SYM_IDLE;
            default:    state_d = SYM_IDLE;
         endcase
      end
   end

   // Strobes are registered from the next state so they coincide with their state.
   always_ff @(posedge clk_sym or posedge rst_sym) begin
      if (rst_sym) begin
         state_q  <= SYM_IDLE;
         delta_q  <= '0;
         iter_q   <= '0;
         conv_q   <= 1'b0;
         tout_q   <= 1'b0;
         selsel_q <= 1'b0;
         selen_q  <= 1'b0;
         decst_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         delta_q  <= delta_d;
         iter_q   <= iter_d;
         conv_q   <= conv_d;
         tout_q   <= tout_d;
         selsel_q <= selsel_d;
         selen_q  <= (state_d == SYM_LOAD) || (state_d == SYM_UPDATE);
         decst_q  <= (state_d == SYM_RUN);
         busy_q   <= (state_d != SYM_IDLE) && (state_d != SYM_DONE);
         done_q   <= (state_d == SYM_DONE);
      end
   end

   assign sel_en     = selen_q;
   assign sel_select = selsel_q;
   assign dec_start  = decst_q;
   assign iter_cnt   = iter_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign converged  = conv_q;
   assign timeout    = tout_q;

endmodule

// File: tb/tb_symm_iter_ctrl.sv
// Scoreboard bench for symm_iter_ctrl: randomized and directed runs against a
// pass-list model, with a negedge monitor checking handshake latencies and results.
module tb_symm_iter_ctrl;

   localparam int unsigned MAX_ITER = 4;
   localparam int unsigned ITER_W   = 5;
   localparam int unsigned DW       = 26;
   localparam int unsigned TOLV     = 64;

   typedef struct {
      int unsigned conv;
      int unsigned tout;
      int unsigned iter;
      int unsigned passes;
   } exp_t;

   logic              clk_sym = 1'b0;
   logic              rst_sym = 1'b1;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic              dec_done = 1'b0;
   logic [DW-1:0]     delta_abs = '0;
   logic              sel_en, sel_select, dec_start, busy, done, converged, timeout;
   logic [ITER_W-1:0] iter_cnt;

   int unsigned n_cmp = 0;
   int unsigned n_fail = 0;
   exp_t        sb[$];
   int unsigned dq[$];

   symm_iter_ctrl #(
      .MAX_ITER(MAX_ITER),
      .ITER_W  (ITER_W),
      .DW      (DW),
      .TOL     (26'd64)
   ) dut (
      .clk_sym   (clk_sym),
      .rst_sym   (rst_sym),
      .start     (start),
      .abort     (abort),
      .dec_done  (dec_done),
      .delta_abs (delta_abs),
      .sel_en    (sel_en),
      .sel_select(sel_select),
      .dec_start (dec_start),
      .iter_cnt  (iter_cnt),
      .busy      (busy),
      .done      (done),
      .converged (converged),
      .timeout   (timeout)
   );

   always #5 clk_sym = ~clk_sym;

   function automatic void check(string nm, longint act, longint exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   function automatic longint outs_all();
      return {sel_en, sel_select, dec_start, busy, done, converged, timeout, iter_cnt};
   endfunction

   // Reference: walk the pass list; first delta within TOL converges, the
   // MAX_ITER-th failing pass times out without loading a new W.
   function automatic exp_t model();
      exp_t e;
      e.conv = 0; e.tout = 0; e.iter = 0; e.passes = 0;
      for (int i = 0; i < dq.size(); i++) begin
         e.passes = i + 1;
         if (dq[i] <= TOLV) begin
            e.conv = 1; e.iter = i;
            break;
         end
         if (i + 1 == MAX_ITER) begin
            e.tout = 1; e.iter = MAX_ITER - 1;
            break;
         end
      end
      return e;
   endfunction

   task automatic pulse_start();
      @(posedge clk_sym); #1 start = 1'b1;
      @(posedge clk_sym); #1 start = 1'b0;
   endtask

   task automatic pulse_dec_done(input int unsigned d);
      @(posedge clk_sym); #1 dec_done = 1'b1; delta_abs = DW'(d);
      @(posedge clk_sym); #1 dec_done = 1'b0; delta_abs = DW'($urandom);
   endtask

   task automatic wait_dec_start(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk_sym);
         if (dec_start) begin ok = 1'b1; break; end
      end
      if (!ok) check("dec_start_wait", 0, 1);
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_sym);
         if (done) begin ok = 1'b1; break; end
      end
      if (!ok) check("done_wait", 0, 1);
   endtask

   task automatic do_run();
      exp_t e;
      bit   ok;
      e = model();
      sb.push_back(e);
      pulse_start();
      for (int p = 0; p < e.passes; p++) begin
         wait_dec_start(ok);
         if (!ok) return;
         repeat ($urandom_range(0, 3)) @(posedge clk_sym);
         pulse_dec_done(dq[p]);
      end
      wait_done(ok);
      repeat (2) @(posedge clk_sym);
   endtask

   // Monitor: latency and result checks, decoupled from stimulus.
   int unsigned cyc = 0, last_start = 0, last_dd = 0, ndec = 0, nupd = 0;
   int          last_evt = 0;
   exp_t        me;

   always @(negedge clk_sym) begin
      cyc++;
      if (rst_sym) begin
         last_evt = 0; ndec = 0; nupd = 0;
      end else begin
         if (start && !abort && !busy && !done) begin
            last_start = cyc; last_evt = 1; ndec = 0; nupd = 0;
         end
         if (dec_done && busy) begin
            last_dd = cyc; last_evt = 2;
         end
         if (sel_en) begin
            if (last_evt == 1) begin
               check("load_latency", cyc - last_start, 1);
               check("load_select", sel_select, 0);
            end else begin
               nupd++;
               check("update_latency", cyc - last_dd, 2);
               check("update_select", sel_select, 1);
            end
         end
         if (dec_start) begin
            ndec++;
            if (last_evt == 1) check("start_to_dec_start", cyc - last_start, 2);
            else               check("dec_done_to_dec_start", cyc - last_dd, 3);
         end
         if (done) begin
            check("done_expected", sb.size() > 0, 1);
            if (sb.size() > 0) begin
               me = sb.pop_front();
               check("converged", converged, me.conv);
               check("timeout", timeout, me.tout);
               check("iter_cnt", iter_cnt, me.iter);
               check("dec_start_count", ndec, me.passes);
               check("update_count", nupd, me.iter);
               check("dec_done_to_done", cyc - last_dd, 2);
               check("busy_at_done", busy, 0);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit          ok;
      int unsigned r;

      // Reset and idle
      repeat (3) @(posedge clk_sym);
      #1 check("outs_in_reset", outs_all(), 0);
      @(negedge clk_sym) rst_sym = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_sym);
         check("outs_idle_after_reset", outs_all(), 0);
      end

      // Directed runs
      dq = {10};                 do_run();
      dq = {500, 200, 64};       do_run();
      dq = {1000, 1000, 1000, 1000}; do_run();
      dq = {1000, 65, 1000, 64}; do_run();

      // Abort in WAIT after one UPDATE (flags start set from a converged run)
      dq = {10}; do_run();
      pulse_start();
      @(negedge clk_sym);
      check("start_clears_converged", converged, 0);
      check("start_clears_timeout", timeout, 0);
      check("load_sel_en", sel_en, 1);
      wait_dec_start(ok);
      pulse_dec_done(1000);
      wait_dec_start(ok);
      @(posedge clk_sym); #1 abort = 1'b1; dec_done = 1'b1; delta_abs = '0;
      @(posedge clk_sym); #1 abort = 1'b0; dec_done = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_iter_cnt", iter_cnt, 1);
      check("abort_sel_select", sel_select, 1);
      check("abort_converged", converged, 0);
      pulse_dec_done(5);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_sym);
         check("late_dec_done_busy", busy, 0);
         check("late_dec_done_done", done, 0);
      end
      dq = {1000, 20}; do_run();

      // Asynchronous reset mid-WAIT with a spurious start
      pulse_start();
      wait_dec_start(ok);
      pulse_dec_done(1000);
      wait_dec_start(ok);
      @(posedge clk_sym);
      #3 rst_sym = 1'b1; start = 1'b1;
      #1 check("async_reset_outs", outs_all(), 0);
      @(negedge clk_sym) start = 1'b0;
      @(negedge clk_sym) rst_sym = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_sym);
         check("post_reset_idle", outs_all(), 0);
      end

      // Randomized runs
      for (int n = 0; n < 30; n++) begin
         dq.delete();
         for (int i = 0; i < MAX_ITER; i++) begin
            r = $urandom_range(0, 9);
            if (r < 2)       dq.push_back($urandom_range(0, TOLV));
            else if (r == 2) dq.push_back(TOLV);
            else if (r == 3) dq.push_back(TOLV + 1);
            else             dq.push_back($urandom_range(TOLV + 1, 5000));
         end
         do_run();
      end

      repeat (3) @(posedge clk_sym);
      check("scoreboard_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
